// File: rtl/countdown_timer.sv
// Loadable down-counter with optional prescaler, pause/abort control,
// auto-reload and a one-cycle done pulse at terminal count.
module countdown_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);
  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] count_n, reload, reload_n;
  logic [PW-1:0]    presc, presc_n;
  logic             done_n, tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      presc  <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      reload <= reload_n;
      presc  <= presc_n;
      done   <= done_n;
    end
  end

  assign busy = (state != IDLE);
  assign tick = (presc == PMAX);

  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload;
    presc_n  = presc;
    done_n   = 1'b0;
    if (abort) begin
      state_n = IDLE;
      count_n = '0;
      presc_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (load_val != '0) begin
              count_n  = load_val;
              reload_n = load_val;
              presc_n  = '0;
              state_n  = RUN;
            end else begin
              done_n = 1'b1;
            end
          end
        end
        RUN, HOLD: begin
          // Leaving HOLD counts in the same edge, so each paused edge costs one cycle.
          if (pause) begin
            state_n = HOLD;
          end else begin
            state_n = RUN;
            presc_n = tick ? '0 : presc + PW'(1);
            if (tick) begin
              if (count == WIDTH'(1)) begin
                done_n = 1'b1;
                if (auto_reload) begin
                  count_n = reload;
                end else begin
                  count_n = '0;
                  state_n = IDLE;
                end
              end else begin
                count_n = count - WIDTH'(1);
              end
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: two timers (PRESCALE 1 and 3) on shared stimulus,
// compared each cycle against an elapsed-cycle arithmetic model.
module tb_countdown_timer;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] load_val;
  logic       start, pause, abort, auto_reload;
  logic [3:0] cnt1, cnt3;
  logic       busy1, busy3, done1, done3;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  countdown_timer #(.WIDTH(4), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .load_val(load_val), .start(start), .pause(pause),
    .abort(abort), .auto_reload(auto_reload), .count(cnt1), .busy(busy1), .done(done1));
  countdown_timer #(.WIDTH(4), .PRESCALE(3)) dut3 (
    .clk(clk), .rst(rst), .load_val(load_val), .start(start), .pause(pause),
    .abort(abort), .auto_reload(auto_reload), .count(cnt3), .busy(busy3), .done(done3));

  always #5 clk = ~clk;

  // Model: count = N - elapsed/P, where elapsed counts unpaused active edges.
  int m_p[2] = '{1, 3};
  bit m_act[2];
  int m_n[2], m_el[2], m_cnt[2];
  bit m_done[2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] = 0; m_n[i] = 0; m_el[i] = 0; m_cnt[i] = 0; m_done[i] = 0;
      end else begin
        m_done[i] = 0;
        if (abort) begin
          m_act[i] = 0; m_cnt[i] = 0;
        end else if (!m_act[i]) begin
          if (start) begin
            if (load_val == 0) m_done[i] = 1;
            else begin
              m_act[i] = 1; m_n[i] = int'(load_val); m_el[i] = 0; m_cnt[i] = m_n[i];
            end
          end
        end else if (!pause) begin
          m_el[i]++;
          if (m_el[i] == m_n[i] * m_p[i]) begin
            m_done[i] = 1;
            m_el[i]   = 0;
            if (auto_reload) m_cnt[i] = m_n[i];
            else begin m_act[i] = 0; m_cnt[i] = 0; end
          end else begin
            m_cnt[i] = m_n[i] - m_el[i] / m_p[i];
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("p1_count", int'(cnt1), m_cnt[0]);
      chk("p1_busy",  int'(busy1), int'(m_act[0]));
      chk("p1_done",  int'(done1), int'(m_done[0]));
      chk("p3_count", int'(cnt3), m_cnt[1]);
      chk("p3_busy",  int'(busy3), int'(m_act[1]));
      chk("p3_done",  int'(done3), int'(m_done[1]));
    end
  end

  // Inputs change just after a negedge; one posedge passes before return.
  task automatic step(input logic st, input logic ab, input logic pa,
                      input logic ar, input logic [3:0] lv);
    start = st; abort = ab; pause = pa; auto_reload = ar; load_val = lv;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ar);
    for (int i = 0; i < n; i++) step(0, 0, 0, ar, 4'd0);
  endtask

  int dn;

  initial begin
    rst = 1'b1; start = 0; abort = 0; pause = 0; auto_reload = 0; load_val = 0;
    cmp_en = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("reset_count", int'(cnt1), 0);
    chk("reset_busy",  int'(busy1), 0);
    chk("reset_done",  int'(done1), 0);
    rst = 1'b0;
    idle(2, 0);

    // Basic countdown from 10
    step(1, 0, 0, 0, 4'd10);
    chk("basic_load", int'(cnt1), 10);
    chk("basic_busy", int'(busy1), 1);
    dn = 0;
    for (int i = 0; i < 9; i++) begin step(0, 0, 0, 0, 4'd0); dn += int'(done1); end
    chk("basic_cnt1", int'(cnt1), 1);
    chk("basic_early_done", dn, 0);
    step(0, 0, 0, 0, 4'd0);
    chk("basic_done", int'(done1), 1);
    chk("basic_idle", int'(busy1), 0);
    step(0, 0, 0, 0, 4'd0);
    chk("basic_done_1cyc", int'(done1), 0);
    step(0, 1, 0, 0, 4'd0);

    // Zero load
    step(1, 0, 0, 0, 4'd0);
    chk("zero_done", int'(done1), 1);
    chk("zero_busy", int'(busy1), 0);
    chk("zero_count", int'(cnt1), 0);
    step(0, 0, 0, 0, 4'd0);
    chk("zero_done_end", int'(done1), 0);

    // Prescale 3, load 4, 5 paused cycles -> done 17 cycles after start
    step(1, 0, 0, 0, 4'd4);
    idle(3, 0);
    chk("pre_cnt_before_pause", int'(cnt3), 3);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 4'd0);
      chk("pre_cnt_frozen", int'(cnt3), 3);
    end
    idle(8, 0);
    chk("pre_not_yet", int'(done3), 0);
    chk("pre_cnt_last", int'(cnt3), 1);
    step(0, 0, 0, 0, 4'd0);
    chk("pre_done17", int'(done3), 1);
    chk("pre_idle", int'(busy3), 0);
    step(0, 1, 0, 0, 4'd0);

    // Auto-reload at full scale with ignored start pulses
    step(1, 0, 0, 1, 4'd15);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 14; i++) step(i % 4 == 1, 0, 0, 1, 4'($urandom_range(0, 15)));
      chk("ar_cnt1", int'(cnt1), 1);
      step(0, 0, 0, 1, 4'd3);
      chk("ar_done", int'(done1), 1);
      chk("ar_reload", int'(cnt1), 15);
    end
    step(0, 1, 0, 0, 4'd0);

    // Abort at count 5, and coincident with terminal tick
    step(1, 0, 0, 0, 4'd10);
    idle(5, 0);
    chk("abort_pre", int'(cnt1), 5);
    step(0, 1, 0, 0, 4'd0);
    chk("abort_cnt", int'(cnt1), 0);
    chk("abort_busy", int'(busy1), 0);
    chk("abort_done", int'(done1), 0);
    step(1, 0, 0, 0, 4'd3);
    idle(2, 0);
    step(0, 1, 0, 0, 4'd0);
    chk("abort_term_done", int'(done1), 0);
    chk("abort_term_cnt", int'(cnt1), 0);

    // Pause on the terminal edge defers the tick
    step(1, 0, 0, 0, 4'd2);
    step(0, 0, 0, 0, 4'd0);
    step(0, 0, 1, 0, 4'd0);
    chk("pause_term_cnt", int'(cnt1), 1);
    chk("pause_term_nodone", int'(done1), 0);
    step(0, 0, 0, 0, 4'd0);
    chk("pause_term_done", int'(done1), 1);
    step(0, 1, 0, 0, 4'd0);

    // Asynchronous reset mid-run
    step(1, 0, 0, 0, 4'd10);
    idle(3, 0);
    chk("rst_pre", int'(cnt1), 7);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_cnt", int'(cnt1), 0);
    chk("rst_async_busy", int'(busy1), 0);
    chk("rst_async_done", int'(done1), 0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0, 0, 4'd3);
    idle(2, 0);
    chk("rst_restart_nodone", int'(done1), 0);
    step(0, 0, 0, 0, 4'd0);
    chk("rst_restart_done", int'(done1), 1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
           4'($urandom_range(0, 15)));
    idle(3, 0);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with start/pause/abort control and a one-cycle done pulse. It mirrors the up-counting wait loops in our benches: instead of counting up to a limit, it loads a value and counts down to zero. It sits beside bench and RTL blocks that need "wait N ticks then signal" behaviour, with an optional clock prescaler and auto-reload for periodic events.

## Interface
- WIDTH, 4: counter width in bits.
- PRESCALE, 1: clk cycles per count tick; must be >= 1.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- load_val  input  WIDTH  start value, sampled only on an accepted start.
- start  input  1  begin a countdown; accepted only in IDLE.
- pause  input  1  level; freezes counting while high.
- abort  input  1  cancel the countdown; returns to IDLE.
- auto_reload  input  1  level, sampled at terminal tick; restarts from the latched value.
- count  output  WIDTH  current count value.
- busy  output  1  high in RUN or HOLD.
- done  output  1  one-cycle pulse at terminal count.

## Operation
- **States:** IDLE, RUN, HOLD. Reset values: state IDLE, count 0, busy 0, done 0, prescaler 0, reload register 0.
- **Control priority**, evaluated at each clk edge: abort > start > pause.
- **IDLE + start, load_val = N > 0:**
  - count <= N, reload register <= N, prescaler <= 0.
  - State goes to RUN.
- **IDLE + start, load_val = 0:** done pulses next cycle; state stays IDLE; count stays 0; busy stays 0.
- **RUN:**
  - The prescaler increments each cycle.
  - A tick occurs when prescaler == PRESCALE-1; the prescaler then wraps to 0.
  - On each tick, count <= count-1.
- **Terminal tick** (tick while count == 1):
  - count <= 0 and done <= 1 for exactly one cycle.
  - If auto_reload = 1: count <= reload register instead of 0, state stays RUN, and done still pulses.
  - If auto_reload = 0: state goes to IDLE.
- **RUN + pause = 1:** go to HOLD. Count and prescaler are frozen; no tick occurs in that cycle.
- **HOLD + pause = 0:** return to RUN. The prescaler resumes from its frozen value, so no tick is lost or duplicated.
- **abort (any state):** state IDLE, count 0, prescaler 0, no done pulse.
- **start in RUN/HOLD:** ignored. load_val changes after an accepted start have no effect.
- **Arithmetic:** count never wraps below 0; decrements are unsigned WIDTH-bit.
- **Reset mid-operation:** all registers return to their reset values immediately, asynchronously; no done pulse is emitted.

## Timing
- All outputs are registered; busy is decoded from the state register.
- **Start acceptance:** start sampled at edge k gives count = N and busy = 1 after edge k.
- **Count sequence:** with PRESCALE = P, the first decrement occurs after edge k+P, and count reaches 0 after edge k+N·P.
- **done and busy at terminal:** done is high for the cycle following edge k+N·P, and busy falls at that same edge when there is no reload.
- **Pause:** every cycle spent in HOLD extends the latency by exactly one cycle.
- **Auto-reload:** gives a done period of exactly N·P cycles.
- **Zero load:** start with load_val = 0 at edge k gives done high in the cycle after edge k.
- **Simultaneous events:**
  - abort on the terminal-tick edge: abort wins, no done.
  - pause on the terminal-tick edge: the tick is suppressed; it completes after resume.

## Test plan
- **Basic countdown:** WIDTH = 4, P = 1, load_val = 10, start one cycle -> count 10,9,…,0 on consecutive cycles; done high exactly once, 10 cycles after start; busy high for 10 cycles.
- **Zero load:** load_val = 0, start -> done pulse the next cycle; busy stays 0; count stays 0.
- **Prescaler with pause:** P = 3, load_val = 4, pause high for 5 cycles mid-run -> done 12+5 = 17 cycles after start; count constant during the pause.
- **Auto-reload at full scale:** auto_reload = 1, load_val = 15, P = 1 -> done every 15 cycles; count goes 1 -> 15 with no 0 visible between; start pulses during the run are ignored.
- **Abort:** abort at count = 5 -> next cycle count 0, busy 0, no done. Abort coincident with the terminal tick -> no done.
- **Async reset:** assert rst mid-run at count = 7, between clock edges -> count, busy, and done go to 0 immediately; after release, a fresh start with load_val = 3 completes in 3 cycles.
